// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready request/response wrapper around the combinational 16-bit ALU.
// Registers the opcode and operands onto the ALU, holds them for SETTLE_CYCLES, then captures the result.
// The opcode is passed through unchanged; its encoding is owned by the ALU's definitions package.
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic [15:0] REQ_A,
    input  logic [15:0] REQ_B,
    input  logic        REQ_CHAIN,
    output logic [1:0]  OP,
    output logic [15:0] INPUTA,
    output logic [15:0] INPUTB,
    input  logic [15:0] OUT,
    input  logic        ZERO,
    input  logic        EQUAL,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_DATA,
    output logic        RSP_ZERO,
    output logic        RSP_EQUAL
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    // Settle window must fit the 4-bit counter and be at least one cycle.
    if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_sequencer: SETTLE_CYCLES=%0d is outside 1..15", SETTLE_CYCLES);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [OP_W-1:0]    op_q,        op_d;
    logic [DATA_W-1:0]  a_q,         a_d;
    logic [DATA_W-1:0]  b_q,         b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
    logic               rsp_zero_q,  rsp_zero_d;
    logic               rsp_equal_q, rsp_equal_d;
    logic [DATA_W-1:0]  last_q,      last_d;

    // Next-state, operand load and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_equal_d = rsp_equal_q;
        last_d      = last_q;

        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    op_d    = REQ_OP;
                    a_d     = REQ_CHAIN ? last_q : REQ_A;
                    b_d     = REQ_B;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == LAST_CNT) begin
                    rsp_data_d  = OUT;
                    rsp_zero_d  = ZERO;
                    rsp_equal_d = EQUAL;
                    last_d      = OUT;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_equal_q <= 1'b0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_equal_q <= rsp_equal_d;
            last_q      <= last_d;
        end
    end

    // Requests are only taken while idle; everything else is straight from flops.
    assign REQ_READY = (state_q == S_IDLE);
    assign OP        = op_q;
    assign INPUTA    = a_q;
    assign INPUTB    = b_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ZERO  = rsp_zero_q;
    assign RSP_EQUAL = rsp_equal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (settle 1 and settle 3), each with a behavioural ALU,
// checked against an operation-level reference model.
module tb_alu_sequencer;

    localparam logic [1:0] K_ADD = 2'd0;
    localparam logic [1:0] K_SUB = 2'd1;
    localparam logic [1:0] K_AND = 2'd2;
    localparam logic [1:0] K_XOR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_op    [2];
    logic [15:0] req_a     [2];
    logic [15:0] req_b     [2];
    logic        req_chain [2];
    logic [1:0]  op_o      [2];
    logic [15:0] ina       [2];
    logic [15:0] inb       [2];
    logic [15:0] alu_out   [2];
    logic        alu_zero  [2];
    logic        alu_equal [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_data  [2];
    logic        rsp_zero  [2];
    logic        rsp_equal [2];

    logic [15:0] model_last [2];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            K_ADD:   return a + b;
            K_SUB:   return a - b;
            K_AND:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign alu_out[g]   = alu_f(op_o[g], ina[g], inb[g]);
        assign alu_zero[g]  = (alu_out[g] == 16'h0000);
        assign alu_equal[g] = (ina[g] == inb[g]);

        alu_sequencer #(.SETTLE_CYCLES((g == 0) ? 1 : 3)) u_dut (
            .CLK       (clk),
            .RESET_N   (rst_n),
            .REQ_VALID (req_valid[g]),
            .REQ_READY (req_ready[g]),
            .REQ_OP    (req_op[g]),
            .REQ_A     (req_a[g]),
            .REQ_B     (req_b[g]),
            .REQ_CHAIN (req_chain[g]),
            .OP        (op_o[g]),
            .INPUTA    (ina[g]),
            .INPUTB    (inb[g]),
            .OUT       (alu_out[g]),
            .ZERO      (alu_zero[g]),
            .EQUAL     (alu_equal[g]),
            .RSP_VALID (rsp_valid[g]),
            .RSP_READY (rsp_ready[g]),
            .RSP_DATA  (rsp_data[g]),
            .RSP_ZERO  (rsp_zero[g]),
            .RSP_EQUAL (rsp_equal[g])
        );
    end

    // One full operation on instance d; hold<0 keeps RSP_READY high from acceptance,
    // otherwise RSP_READY stays low for hold cycles after RSP_VALID rises.
    task automatic run_op(input int d, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic chain, input int hold, output logic [15:0] got);
        int          s;
        int          waitc;
        logic [15:0] ea;
        logic [15:0] eo;
        logic        ez;
        logic        ee;
        s  = settle_of(d);
        ea = chain ? model_last[d] : a;
        eo = alu_f(op, ea, b);
        ez = (eo == 16'h0000);
        ee = (ea == b);
        waitc = 0;
        while (req_ready[d] !== 1'b1 && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        total_cnt++;
        if (req_ready[d] !== 1'b1) $display("FAIL ready_wait[%0d]: req_ready=%b required 1", d, req_ready[d]);
        else pass_cnt++;

        req_op[d] = op; req_a[d] = a; req_b[d] = b; req_chain[d] = chain; req_valid[d] = 1'b1;
        rsp_ready[d] = (hold < 0);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_a[d] = 16'($urandom); req_b[d] = 16'($urandom); req_op[d] = 2'($urandom);

        total_cnt++;
        if ({op_o[d], ina[d], inb[d], req_ready[d]} !== {op, ea, b, 1'b0})
            $display("FAIL operands[%0d]: got op=%h a=%h b=%h rdy=%b required op=%h a=%h b=%h rdy=0",
                     d, op_o[d], ina[d], inb[d], req_ready[d], op, ea, b);
        else pass_cnt++;

        for (int k = 1; k <= s; k++) begin
            @(posedge clk); #1;
            if (k < s) begin
                total_cnt++;
                if ({rsp_valid[d], req_ready[d], op_o[d], ina[d], inb[d]} !== {2'b00, op, ea, b})
                    $display("FAIL exec_hold[%0d]: vld=%b rdy=%b a=%h b=%h required vld=0 rdy=0 a=%h b=%h",
                             d, rsp_valid[d], req_ready[d], ina[d], inb[d], ea, b);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({rsp_valid[d], req_ready[d], rsp_data[d], rsp_zero[d], rsp_equal[d]} !== {2'b10, eo, ez, ee})
            $display("FAIL response[%0d]: vld=%b rdy=%b data=%h z=%b eq=%b required vld=1 rdy=0 data=%h z=%b eq=%b",
                     d, rsp_valid[d], req_ready[d], rsp_data[d], rsp_zero[d], rsp_equal[d], eo, ez, ee);
        else pass_cnt++;
        got = rsp_data[d];

        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            total_cnt++;
            if ({rsp_valid[d], req_ready[d], rsp_data[d], rsp_zero[d], rsp_equal[d], ina[d], inb[d]} !==
                {2'b10, eo, ez, ee, ea, b})
                $display("FAIL stall_hold[%0d]: vld=%b data=%h a=%h b=%h required vld=1 data=%h a=%h b=%h",
                         d, rsp_valid[d], rsp_data[d], ina[d], inb[d], eo, ea, b);
            else pass_cnt++;
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        total_cnt++;
        if ({rsp_valid[d], req_ready[d], rsp_data[d], rsp_zero[d], rsp_equal[d]} !== {2'b01, eo, ez, ee})
            $display("FAIL handshake[%0d]: vld=%b rdy=%b data=%h required vld=0 rdy=1 data=%h",
                     d, rsp_valid[d], req_ready[d], rsp_data[d], eo);
        else pass_cnt++;
        model_last[d] = eo;
    endtask

    task automatic test_reset();
        logic [52:0] obs;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_op[d] = 2'b00; req_a[d] = '0; req_b[d] = '0;
            req_chain[d] = 1'b0; rsp_ready[d] = 1'b0; model_last[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            obs = {op_o[d], ina[d], inb[d], rsp_valid[d], rsp_data[d], rsp_zero[d], rsp_equal[d]};
            total_cnt++;
            if (obs !== 53'd0) $display("FAIL reset_outputs[%0d]: got %h required 0", d, obs);
            else pass_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            total_cnt++;
            if ({req_ready[d], rsp_valid[d]} !== 2'b10)
                $display("FAIL reset_release[%0d]: rdy=%b vld=%b required rdy=1 vld=0", d, req_ready[d], rsp_valid[d]);
            else pass_cnt++;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic        ez;
        logic        ee;
    } vec_t;

    task automatic test_basic_ops();
        vec_t        v [6];
        logic [15:0] got;
        v[0] = '{K_ADD, 16'h0004, 16'h0004, 16'h0008, 1'b0, 1'b1};
        v[1] = '{K_SUB, 16'h0004, 16'h0004, 16'h0000, 1'b1, 1'b1};
        v[2] = '{K_XOR, 16'h0004, 16'h0003, 16'h0007, 1'b0, 1'b0};
        v[3] = '{K_AND, 16'h0004, 16'h0003, 16'h0000, 1'b1, 1'b0};
        v[4] = '{K_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        v[5] = '{K_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(0, v[i].op, v[i].a, v[i].b, 1'b0, -1, got);
            total_cnt++;
            if ({got, rsp_zero[0], rsp_equal[0]} !== {v[i].exp, v[i].ez, v[i].ee})
                $display("FAIL plan_vec%0d: data=%h z=%b eq=%b required data=%h z=%b eq=%b",
                         i, got, rsp_zero[0], rsp_equal[0], v[i].exp, v[i].ez, v[i].ee);
            else pass_cnt++;
        end
    endtask

    task automatic test_chain();
        logic [15:0] got;
        run_op(0, K_ADD, 16'h0010, 16'h0005, 1'b0, 0, got);
        total_cnt++;
        if (got !== 16'h0015) $display("FAIL chain_first: data=%h required 0015", got);
        else pass_cnt++;
        run_op(0, K_SUB, 16'hBEEF, 16'h0015, 1'b1, 1, got);
        total_cnt++;
        if ({got, rsp_zero[0], rsp_equal[0]} !== {16'h0000, 1'b1, 1'b1})
            $display("FAIL chain_second: data=%h z=%b eq=%b required data=0000 z=1 eq=1", got, rsp_zero[0], rsp_equal[0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] got;
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            run_op(i % 2, 2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 2) == 0),
                   int'($urandom_range(0, 4)) - 1, got);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e1;
        logic [15:0] e2;
        e1 = alu_f(K_SUB, 16'h0100, 16'h0001);
        e2 = alu_f(K_AND, 16'hF0F0, 16'h3C3C);
        req_op[1] = K_SUB; req_a[1] = 16'h0100; req_b[1] = 16'h0001; req_chain[1] = 1'b0;
        req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_op[1] = K_AND; req_a[1] = 16'hF0F0; req_b[1] = 16'h3C3C;
        repeat (3) begin
            @(posedge clk); #1;
        end
        total_cnt++;
        if ({rsp_valid[1], rsp_data[1]} !== {1'b1, e1})
            $display("FAIL bp_first_rsp: vld=%b data=%h required vld=1 data=%h", rsp_valid[1], rsp_data[1], e1);
        else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({rsp_valid[1], rsp_data[1], rsp_zero[1], rsp_equal[1], req_ready[1], op_o[1], ina[1], inb[1]} !==
                {1'b1, e1, 1'b0, 1'b0, 1'b0, K_SUB, 16'h0100, 16'h0001})
                $display("FAIL bp_frozen%0d: vld=%b data=%h rdy=%b op=%h a=%h b=%h required vld=1 data=%h rdy=0 op=1 a=0100 b=0001",
                         c, rsp_valid[1], rsp_data[1], req_ready[1], op_o[1], ina[1], inb[1], e1);
            else pass_cnt++;
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        total_cnt++;
        if ({rsp_valid[1], req_ready[1]} !== 2'b01)
            $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", rsp_valid[1], req_ready[1]);
        else pass_cnt++;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        total_cnt++;
        if ({op_o[1], ina[1], inb[1], req_ready[1]} !== {K_AND, 16'hF0F0, 16'h3C3C, 1'b0})
            $display("FAIL bp_second_accept: op=%h a=%h b=%h rdy=%b required op=2 a=f0f0 b=3c3c rdy=0",
                     op_o[1], ina[1], inb[1], req_ready[1]);
        else pass_cnt++;
        repeat (3) begin
            @(posedge clk); #1;
        end
        total_cnt++;
        if ({rsp_valid[1], rsp_data[1]} !== {1'b1, e2})
            $display("FAIL bp_second_rsp: vld=%b data=%h required vld=1 data=%h", rsp_valid[1], rsp_data[1], e2);
        else pass_cnt++;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        model_last[1] = e2;
    endtask

    task automatic test_reset_mid_exec();
        logic [52:0] obs;
        logic [15:0] got;
        int          pulses;
        req_op[1] = K_XOR; req_a[1] = 16'h1234; req_b[1] = 16'h0042; req_chain[1] = 1'b0;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_last[0] = '0;
        model_last[1] = '0;
        obs = {op_o[1], ina[1], inb[1], rsp_valid[1], rsp_data[1], rsp_zero[1], rsp_equal[1]};
        total_cnt++;
        if (obs !== 53'd0) $display("FAIL reset_mid_exec: got %h required 0", obs);
        else pass_cnt++;
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid[1] !== 1'b0) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid[1] !== 1'b0) pulses++;
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL reset_no_rsp: rsp_valid seen %0d times required 0", pulses);
        else pass_cnt++;
        run_op(1, K_ADD, 16'hBEEF, 16'h0007, 1'b1, 0, got);
        total_cnt++;
        if (got !== 16'h0007) $display("FAIL reset_chain1: data=%h required 0007", got);
        else pass_cnt++;
        run_op(0, K_XOR, 16'hBEEF, 16'h00A5, 1'b1, -1, got);
        total_cnt++;
        if (got !== 16'h00A5) $display("FAIL reset_chain0: data=%h required 00a5", got);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_chain();
        test_random();
        test_backpressure();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
